// File: rtl/hirose_hash.sv
// Hirose double-block-length hash controller driving external cipher cores.
// Optional IV load ports are enabled by defining HIROSE_IV_LOAD_EN.
module hirose_hash #(
    parameter int                 BLOCK_W  = 64,
    parameter int                 MSG_W    = 64,
    parameter logic [BLOCK_W-1:0] C_CONST  = 64'hFFFF_FFFF_FFFF_FFFF,
    parameter int                 PARALLEL = 1,
    parameter logic [BLOCK_W-1:0] IV_G     = '0,
    parameter logic [BLOCK_W-1:0] IV_H     = '0,
    localparam int                KEY_W    = BLOCK_W + MSG_W
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef HIROSE_IV_LOAD_EN
    input  logic                 iv_load,
    input  logic [BLOCK_W-1:0]   iv_g,
    input  logic [BLOCK_W-1:0]   iv_h,
`endif
    input  logic                 msg_valid,
    output logic                 msg_ready,
    input  logic [MSG_W-1:0]     msg_data,
    input  logic                 msg_last,
    output logic                 digest_valid,
    output logic [2*BLOCK_W-1:0] digest,
    input  logic                 digest_ack,
    output logic                 c0_start,
    output logic                 c1_start,
    output logic [KEY_W-1:0]     c0_key,
    output logic [KEY_W-1:0]     c1_key,
    output logic [BLOCK_W-1:0]   c0_block,
    output logic [BLOCK_W-1:0]   c1_block,
    input  logic                 c0_done,
    input  logic                 c1_done,
    input  logic [BLOCK_W-1:0]   c0_result,
    input  logic [BLOCK_W-1:0]   c1_result,
    output logic                 busy
);

    typedef enum logic [2:0] {
        IDLE, REQ_G, WAIT_G, REQ_H, WAIT_H, UPDATE, DIGEST
    } state_t;

    localparam bit PAR = (PARALLEL != 0);

    state_t             state_q, state_d;
    logic [BLOCK_W-1:0] g_q, h_q;
    logic [BLOCK_W-1:0] blk0_q, blk1_q;
    logic [BLOCK_W-1:0] r0_q, r1_q;
    logic [KEY_W-1:0]   key_q;
    logic               last_q, d0_q, d1_q;
    logic               accept;
    logic [BLOCK_W-1:0] g_cur, h_cur, iv_g_r, iv_h_r;

`ifdef HIROSE_IV_LOAD_EN
    logic               load_iv;
    logic [BLOCK_W-1:0] ivg_q, ivh_q;

    assign load_iv = iv_load && (state_q == IDLE);
    assign g_cur   = load_iv ? iv_g : g_q;
    assign h_cur   = load_iv ? iv_h : h_q;
    assign iv_g_r  = ivg_q;
    assign iv_h_r  = ivh_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ivg_q <= IV_G;
            ivh_q <= IV_H;
        end else if (load_iv) begin
            ivg_q <= iv_g;
            ivh_q <= iv_h;
        end
    end
`else
    assign g_cur  = g_q;
    assign h_cur  = h_q;
    assign iv_g_r = IV_G;
    assign iv_h_r = IV_H;
`endif

    assign msg_ready    = (state_q == IDLE) && !rst;
    assign accept       = msg_valid && msg_ready;
    assign busy         = (state_q != IDLE);
    assign digest_valid = (state_q == DIGEST);
    assign digest       = digest_valid ? {g_q, h_q} : '0;
    assign c0_start     = (state_q == REQ_G) || (state_q == REQ_H);
    assign c1_start     = PAR && (state_q == REQ_G);
    assign c0_key       = key_q;
    assign c1_key       = PAR ? key_q : '0;
    assign c0_block     = blk0_q;
    assign c1_block     = PAR ? blk1_q : '0;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (accept) state_d = REQ_G;
            REQ_G:  state_d = WAIT_G;
            WAIT_G: begin
                if (PAR) begin
                    if ((d0_q || c0_done) && (d1_q || c1_done))
                        state_d = UPDATE;
                end else if (d0_q) begin
                    state_d = REQ_H;
                end
            end
            REQ_H:  state_d = WAIT_H;
            WAIT_H: if (c0_done) state_d = UPDATE;
            UPDATE: state_d = last_q ? DIGEST : IDLE;
            DIGEST: if (digest_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            g_q     <= IV_G;
            h_q     <= IV_H;
            blk0_q  <= '0;
            blk1_q  <= '0;
            r0_q    <= '0;
            r1_q    <= '0;
            key_q   <= '0;
            last_q  <= 1'b0;
            d0_q    <= 1'b0;
            d1_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                last_q <= msg_last;
                key_q  <= {h_cur, msg_data};
                blk0_q <= g_cur;
                blk1_q <= g_cur ^ C_CONST;
            end
            unique case (state_q)
                IDLE: begin
                    g_q <= g_cur;
                    h_q <= h_cur;
                end
                REQ_G: begin
                    d0_q <= 1'b0;
                    d1_q <= 1'b0;
                end
                WAIT_G: begin
                    if (c0_done && !d0_q) begin
                        d0_q <= 1'b1;
                        r0_q <= c0_result;
                    end
                    if (PAR && c1_done && !d1_q) begin
                        d1_q <= 1'b1;
                        r1_q <= c1_result;
                    end
                    // serial: channel 0 is reused for the H path
                    if (state_d == REQ_H)
                        blk0_q <= g_q ^ C_CONST;
                end
                WAIT_H: if (c0_done) r1_q <= c0_result;
                UPDATE: begin
                    g_q <= g_q ^ r0_q;
                    h_q <= g_q ^ C_CONST ^ r1_q;
                end
                DIGEST: begin
                    if (digest_ack) begin
                        g_q <= iv_g_r;
                        h_q <= iv_h_r;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hirose_hash.sv
// Bench for hirose_hash: parallel and serial instances with stub ciphers.
module tb_hirose_hash;

    localparam logic [63:0] C  = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MA = 64'h0123456789ABCDEF;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         p_valid, p_ready, p_last, p_dv, p_ack, p_busy;
    logic [63:0]  p_data;
    logic [127:0] p_dig, p_c0k, p_c1k;
    logic         p_c0s, p_c1s, p_c0d, p_c1d;
    logic [63:0]  p_c0b, p_c1b, p_c0r, p_c1r;

    logic         s_valid, s_ready, s_last, s_dv, s_ack, s_busy;
    logic [63:0]  s_data;
    logic [127:0] s_dig, s_c0k, s_c1k;
    logic         s_c0s, s_c1s, s_c0d, s_c1d;
    logic [63:0]  s_c0b, s_c1b, s_c0r, s_c1r;

    hirose_hash #(.PARALLEL(1)) u_par (
        .clk(clk), .rst(rst),
        .msg_valid(p_valid), .msg_ready(p_ready),
        .msg_data(p_data), .msg_last(p_last),
        .digest_valid(p_dv), .digest(p_dig), .digest_ack(p_ack),
        .c0_start(p_c0s), .c1_start(p_c1s),
        .c0_key(p_c0k), .c1_key(p_c1k),
        .c0_block(p_c0b), .c1_block(p_c1b),
        .c0_done(p_c0d), .c1_done(p_c1d),
        .c0_result(p_c0r), .c1_result(p_c1r),
        .busy(p_busy)
    );

    hirose_hash #(.PARALLEL(0)) u_ser (
        .clk(clk), .rst(rst),
        .msg_valid(s_valid), .msg_ready(s_ready),
        .msg_data(s_data), .msg_last(s_last),
        .digest_valid(s_dv), .digest(s_dig), .digest_ack(s_ack),
        .c0_start(s_c0s), .c1_start(s_c1s),
        .c0_key(s_c0k), .c1_key(s_c1k),
        .c0_block(s_c0b), .c1_block(s_c1b),
        .c0_done(s_c0d), .c1_done(s_c1d),
        .c0_result(s_c0r), .c1_result(s_c1r),
        .busy(s_busy)
    );

    // stub cipher: mode 0 is x ^ k_lo, mode 1 is a nonlinear keyed permutation
    function automatic logic [63:0] enc(input logic [127:0] k,
                                        input logic [63:0] x, input bit md);
        if (md) return (x + k[63:0]) ^ {k[126:64], k[127]};
        return x ^ k[63:0];
    endfunction

    int   lat0 = 3, lat1 = 3;
    bit   smode = 1'b0;
    logic stray0 = 1'b0;
    bit   s_c1_seen = 1'b0;

    int p0_cnt = 0, p1_cnt = 0, s0_cnt = 0;
    logic [127:0] p0_k, p1_k, s0_k;
    logic [63:0]  p0_x, p1_x, s0_x;
    logic         p0_dr = 1'b0, p1_dr = 1'b0, s0_dr = 1'b0;
    logic [63:0]  p0_rr = '0, p1_rr = '0, s0_rr = '0;

    assign p_c0d = p0_dr | stray0;
    assign p_c0r = p0_rr;
    assign p_c1d = p1_dr;
    assign p_c1r = p1_rr;
    assign s_c0d = s0_dr;
    assign s_c0r = s0_rr;
    assign s_c1d = 1'b0;
    assign s_c1r = '0;

    always @(posedge clk) begin
        p0_dr <= 1'b0;
        if (p0_cnt == 1) begin p0_dr <= 1'b1; p0_rr <= enc(p0_k, p0_x, smode); end
        if (p0_cnt > 0) p0_cnt <= p0_cnt - 1;
        if (p_c0s) begin p0_cnt <= lat0 - 1; p0_k <= p_c0k; p0_x <= p_c0b; end
    end

    always @(posedge clk) begin
        p1_dr <= 1'b0;
        if (p1_cnt == 1) begin p1_dr <= 1'b1; p1_rr <= enc(p1_k, p1_x, smode); end
        if (p1_cnt > 0) p1_cnt <= p1_cnt - 1;
        if (p_c1s) begin p1_cnt <= lat1 - 1; p1_k <= p_c1k; p1_x <= p_c1b; end
    end

    always @(posedge clk) begin
        s0_dr <= 1'b0;
        if (s0_cnt == 1) begin s0_dr <= 1'b1; s0_rr <= enc(s0_k, s0_x, smode); end
        if (s0_cnt > 0) s0_cnt <= s0_cnt - 1;
        if (s_c0s) begin s0_cnt <= lat0 - 1; s0_k <= s_c0k; s0_x <= s_c0b; end
        if (s_c1s) s_c1_seen <= 1'b1;
    end

    int tests = 0, fails = 0;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int           g_n, g_n2;
    logic [127:0] g_key;
    logic [63:0]  g_b0, g_b1, g_b0h;

    task automatic send(input bit ser, input logic [63:0] m, input bit last);
        int w = 0;
        int starts = 0;
        while (!(ser ? s_ready : p_ready) && w < 200) begin step(); w++; end
        if (w >= 200) chk("ready_timeout", ser ? s_ready : p_ready, 1);
        if (ser) begin s_data = m; s_last = last; s_valid = 1'b1; end
        else     begin p_data = m; p_last = last; p_valid = 1'b1; end
        step();
        s_valid = 1'b0;
        p_valid = 1'b0;
        g_n = 1; g_n2 = 0; g_key = '0; g_b0 = '0; g_b1 = '0; g_b0h = '0;
        while (g_n < 200) begin
            if (ser ? s_c0s : p_c0s) begin
                starts++;
                if (starts == 1) begin
                    g_key = ser ? s_c0k : p_c0k;
                    g_b0  = ser ? s_c0b : p_c0b;
                    g_b1  = ser ? s_c1b : p_c1b;
                end
                if (starts == 2) begin
                    g_n2  = g_n;
                    g_b0h = ser ? s_c0b : p_c0b;
                end
            end
            if (last ? (ser ? s_dv : p_dv) : (ser ? s_ready : p_ready)) break;
            step();
            g_n++;
        end
        if (g_n >= 200) chk("done_timeout", last ? (ser ? s_dv : p_dv) : 0, 1);
    endtask

    task automatic ack(input bit ser);
        if (ser) s_ack = 1'b1; else p_ack = 1'b1;
        step();
        s_ack = 1'b0;
        p_ack = 1'b0;
    endtask

    typedef struct {
        bit           ser;
        logic [63:0]  m;
        bit           last;
        int           lat;
        logic [127:0] key;
        logic [63:0]  b0;
        logic [63:0]  b1;
        logic [127:0] dig;
        int           n2;
        logic [63:0]  b0h;
    } vec_t;

    vec_t tab[4];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] dig0;
        logic [63:0]  mg, mh, m, ng;
        bit           dv_seen;
        int           nb;

        tab[0] = '{0, MA, 1, 6, {64'h0, MA}, 64'h0, C, {MA, MA}, 0, 64'h0};
        tab[1] = '{0, 64'h1, 0, 6, {64'h0, 64'h1}, 64'h0, C, 128'h0, 0, 64'h0};
        tab[2] = '{0, 64'h2, 1, 6, {64'h1, 64'h2}, 64'h1, C ^ 64'h1,
                   {64'h2, 64'h2}, 0, 64'h0};
        tab[3] = '{1, MA, 1, 11, {64'h0, MA}, 64'h0, 64'h0, {MA, MA}, 6, C};

        p_valid = 0; p_last = 0; p_data = '0; p_ack = 0;
        s_valid = 0; s_last = 0; s_data = '0; s_ack = 0;
        rst = 1'b1;
        step();
        step();
        chk("ready_in_rst", p_ready, 0);
        rst = 1'b0;
        step();
        chk("rst_ready", p_ready, 1);
        chk("rst_dv", p_dv, 0);
        chk("rst_busy", p_busy, 0);
        chk("rst_digest", p_dig, 0);
        chk("rst_start", {p_c0s, p_c1s}, 0);
        chk("rst_key", p_c0k, 0);
        chk("rst_blocks", {p_c0b, p_c1b}, 0);

        for (int i = 0; i < 4; i++) begin
            send(tab[i].ser, tab[i].m, tab[i].last);
            chk($sformatf("v%0d_latency", i), g_n, tab[i].lat);
            chk($sformatf("v%0d_key", i), g_key, tab[i].key);
            chk($sformatf("v%0d_block0", i), g_b0, tab[i].b0);
            chk($sformatf("v%0d_block1", i), g_b1, tab[i].b1);
            chk($sformatf("v%0d_start2", i), g_n2, tab[i].n2);
            chk($sformatf("v%0d_block0_h", i), g_b0h, tab[i].b0h);
            if (tab[i].last) begin
                chk($sformatf("v%0d_digest", i),
                    tab[i].ser ? s_dig : p_dig, tab[i].dig);
                ack(tab[i].ser);
                chk($sformatf("v%0d_ready_after_ack", i),
                    tab[i].ser ? s_ready : p_ready, 1);
                chk($sformatf("v%0d_dv_after_ack", i),
                    tab[i].ser ? s_dv : p_dv, 0);
            end
        end
        chk("ser_c1_never", s_c1_seen, 0);

        // early c1_done and a stray c0_done while idle
        lat0 = 5;
        lat1 = 3;
        stray0 = 1'b1;
        step();
        stray0 = 1'b0;
        chk("stray_busy", p_busy, 0);
        chk("stray_ready", p_ready, 1);
        send(0, MA, 1);
        chk("skew_latency", g_n, 8);
        chk("skew_digest", p_dig, {MA, MA});
        ack(0);
        lat0 = 3;

        // reset in WAIT_G, late done afterwards
        send(0, 64'h5, 0);
        p_data = 64'h7; p_last = 1'b0; p_valid = 1'b1;
        step();
        p_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        dv_seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (p_dv) dv_seen = 1'b1;
            step();
        end
        chk("abort_no_dv", dv_seen, 0);
        chk("abort_ready", p_ready, 1);
        chk("abort_busy", p_busy, 0);
        send(0, 64'h9, 1);
        chk("abort_iv_key", g_key, {64'h0, 64'h9});
        chk("abort_iv_block", g_b0, 0);
        chk("abort_digest", p_dig, {64'h9, 64'h9});
        ack(0);

        // digest held while ack is low
        send(0, 64'hA5A5_5A5A_0F0F_F0F0, 1);
        dig0 = p_dig;
        chk("hold_digest", dig0, {64'hA5A5_5A5A_0F0F_F0F0, 64'hA5A5_5A5A_0F0F_F0F0});
        for (int k = 0; k < 10; k++) begin
            step();
            chk($sformatf("hold%0d_dv", k), p_dv, 1);
            chk($sformatf("hold%0d_digest", k), p_dig, dig0);
            chk($sformatf("hold%0d_ready", k), p_ready, 0);
        end
        ack(0);
        chk("hold_ack_ready", p_ready, 1);
        chk("hold_ack_dv", p_dv, 0);
        send(0, 64'h3, 1);
        chk("hold_iv_key", g_key, {64'h0, 64'h3});
        chk("hold_iv_block", g_b0, 0);
        ack(0);

        // random multi-block messages against the reference model
        smode = 1'b1;
        for (int r = 0; r < 24; r++) begin
            mg = '0;
            mh = '0;
            nb = $urandom_range(1, 4);
            lat0 = $urandom_range(2, 6);
            lat1 = $urandom_range(2, 6);
            for (int b = 0; b < nb; b++) begin
                m = {$urandom, $urandom};
                send(r[0], m, b == nb - 1);
                ng = enc({mh, m}, mg, 1'b1) ^ mg;
                mh = enc({mh, m}, mg ^ C, 1'b1) ^ mg ^ C;
                mg = ng;
            end
            chk($sformatf("rand%0d_digest", r), r[0] ? s_dig : p_dig, {mg, mh});
            ack(r[0]);
        end
        chk("ser_c1_never_rand", s_c1_seen, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
